puf_resp_collector: RTL and testbench
=====================================

Name: puf_resp_collector

Overview:
- Sits directly downstream of puf_top, in the system clock domain.
- Drives puf_top's i_en and captures o_count_set on each o_valid.
- Repeats the evaluation N_EVAL times, then majority-votes each bit.
- Presents the stable CNT_SET-bit response on a valid/ready interface to the key/ID logic.

Parameters:
- CNT_SET, 32: response width; equals puf_top CNT_SET.
- N_EVAL, 5: evaluations per response. Must be odd, 1..15.
- TIMEOUT, 1024: max clk cycles to wait for o_valid per evaluation.
- VW, $clog2(N_EVAL+1): width of each per-bit vote counter.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- i_start, in, 1: request one response; sampled only in IDLE.
- o_busy, out, 1: high in every state except IDLE.
- o_puf_en, out, 1: to puf_top i_en.
- i_puf_valid, in, 1: from puf_top o_valid; asynchronous to clk.
- i_puf_count_set, in, CNT_SET: from puf_top o_count_set; stable while i_puf_valid is high.
- o_resp_valid, out, 1: response available.
- i_resp_ready, in, 1: consumer accepts the response.
- o_resp, out, CNT_SET: majority-voted response.
- o_err, out, 1: timeout flag; sticky until the next accepted i_start.

Behaviour:
- Reset (asynchronous, active-low): all of the following clear immediately.
  - Outputs: o_busy, o_puf_en, o_resp_valid, o_resp, o_err = 0.
  - Internal: synchronizer flops, vote counters, eval count, timeout count = 0.
  - State = IDLE.
- Synchronization:
  - i_puf_valid passes through a 2-flop synchronizer to give v_s.
  - rise = v_s & ~v_s_d.
  - i_puf_count_set is sampled directly in the rise cycle; it is quasi-static by then.
- FSM states: IDLE, RUN, GAP, OUT.
- IDLE:
  - i_start=1 moves to RUN next cycle.
  - On that transition: o_err<=0, eval_cnt<=0, vote counters<=0, o_puf_en<=1.
- RUN:
  - o_puf_en=1; tmo counter increments each cycle.
  - On rise: for each bit i with count_set[i]=1, vote[i]++; eval_cnt++; tmo<=0; o_puf_en<=0; go to GAP.
  - Rise takes priority if it occurs in the same cycle tmo reaches TIMEOUT-1.
  - If tmo reaches TIMEOUT-1 with no rise: o_err<=1, o_puf_en<=0, go to IDLE. No response is produced.
- GAP:
  - o_puf_en=0; wait for v_s==0.
  - When v_s==0 and eval_cnt==N_EVAL: o_resp[i] <= (vote[i] > N_EVAL/2); o_resp_valid<=1; go to OUT.
  - When v_s==0 and eval_cnt<N_EVAL: o_puf_en<=1; go to RUN.
  - The GAP timeout also applies: v_s stuck high for TIMEOUT cycles gives o_err<=1 and IDLE.
- OUT:
  - o_resp and o_resp_valid are held stable until i_resp_ready=1.
  - On the handshake cycle: o_resp_valid<=0, go to IDLE. o_resp keeps its value.
- i_start outside IDLE: ignored, with no queuing.
- Latency per evaluation, rise to capture: 3 clk cycles after the i_puf_valid edge (2-flop synchronizer plus edge register).
- Vote counters never overflow, since the maximum count is N_EVAL.
- Reset asserted mid-operation: FSM aborts immediately and o_puf_en drops to 0. A fresh start after reset yields a result independent of the aborted run.

Decomposition:
- Shared package puf_pkg holds:
  - the state enum (IDLE, RUN, GAP, OUT);
  - a function computing VW from N_EVAL;
  - a compile-time check that N_EVAL is odd.
- One sub-module: puf_sync2, a 2-flop synchronizer with async active-low reset and parameterized width. It is reused for any other puf_top → system-domain crossing.

Test Plan:
- Single evaluation, N_EVAL=1: start, behavioural PUF model returns 32'hA5A5_0F0F → o_resp=32'hA5A5_0F0F, o_resp_valid=1, o_err=0, o_puf_en pulsed once.
- Majority vote, N_EVAL=3: evaluations return 32'hA5A5A5A5, 32'hA5A5A5A4, 32'h5A5A5A5A → o_resp=32'hA5A5A5A4. Exactly 3 o_puf_en pulses, each dropping within 1 cycle of capture.
- Backpressure:
  - Hold i_resp_ready=0 for 10 cycles in OUT and pulse i_start during them → o_resp_valid and o_resp stay stable, and the start is ignored.
  - Then set ready=1 → IDLE next cycle, o_busy=0.
- Timeout, TIMEOUT=64: never assert i_puf_valid → o_err=1 exactly 64 cycles after RUN entry, o_puf_en=0, o_busy=0, no o_resp_valid. A subsequent start clears o_err.
- Reset mid-run, N_EVAL=3: assert rst_n=0 during the second RUN → all outputs 0 asynchronously, without waiting for a clk edge. A new run then returning 32'hFFFF_0000 three times gives o_resp=32'hFFFF_0000.
- Slow valid release: keep i_puf_valid high for 20 cycles after capture → FSM stays in GAP with o_puf_en=0, and re-enters RUN only after v_s falls.

Source files
------------

// File: rtl/puf_pkg.sv
// -----------------------------------------------------------------------------
// puf_pkg
// Shared definitions for the PUF response collector:
//   - state_e      : collector FSM states (IDLE, RUN, GAP, OUT)
//   - vote_width() : width of a per-bit vote counter able to hold 0..n_eval
//   - n_eval_ok()  : legality check for the evaluation count (odd, 1..15)
// -----------------------------------------------------------------------------
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // A counter that must reach n_eval needs clog2(n_eval+1) bits.
  function automatic int vote_width(input int n_eval);
    return $clog2(n_eval + 1);
  endfunction

  // Majority voting needs an odd count so a tie can never occur.
  function automatic bit n_eval_ok(input int n_eval);
    return ((n_eval % 2) == 1) && (n_eval >= 1) && (n_eval <= 15);
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// -----------------------------------------------------------------------------
// puf_sync2
// Two-flop synchronizer bringing puf_top-domain signals into the system clock
// domain. Width is parameterized so it can be reused for other crossings.
// Ports:
//   clk   : destination (system) clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)
// -----------------------------------------------------------------------------
module puf_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;

  // Two back-to-back stages; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
      q      <= '0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/puf_resp_collector.sv
// -----------------------------------------------------------------------------
// puf_resp_collector
// Drives puf_top through N_EVAL evaluations, accumulates per-bit "1" votes from
// each captured count set, and presents the bitwise majority as a stable
// response on a valid/ready interface.
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   i_start           : request one response (sampled only in IDLE)
//   o_busy            : high whenever the FSM is not IDLE
//   o_puf_en          : enable to puf_top
//   i_puf_valid       : puf_top result valid (asynchronous to clk)
//   i_puf_count_set   : puf_top result, stable while i_puf_valid is high
//   o_resp_valid      : majority-voted response available
//   i_resp_ready      : consumer accepts the response
//   o_resp            : majority-voted response
//   o_err             : sticky timeout flag, cleared by the next accepted start
// -----------------------------------------------------------------------------
module puf_resp_collector
  import puf_pkg::*;
#(
  parameter int CNT_SET = 32,
  parameter int N_EVAL  = 5,
  parameter int TIMEOUT = 1024,
  parameter int VW      = vote_width(N_EVAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_puf_en,
  input  logic               i_puf_valid,
  input  logic [CNT_SET-1:0] i_puf_count_set,
  output logic               o_resp_valid,
  input  logic               i_resp_ready,
  output logic [CNT_SET-1:0] o_resp,
  output logic               o_err
);

  if (!n_eval_ok(N_EVAL)) begin : g_bad_n_eval
    $error("puf_resp_collector: N_EVAL must be odd and within 1..15");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("puf_resp_collector: TIMEOUT must be at least 2");
  end

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [VW-1:0] EVAL_ALL = VW'(N_EVAL);
  localparam logic [VW-1:0] HALF     = VW'(N_EVAL / 2);

  state_e             state_r;
  logic               v_sync_s;
  logic               v_dly_r;
  logic               rise_s;
  logic [VW-1:0]      vote_r [CNT_SET];
  logic [VW-1:0]      eval_cnt_r;
  logic [TW-1:0]      tmo_r;
  logic [CNT_SET-1:0] maj_s;

  puf_sync2 #(.W(1)) u_valid_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_puf_valid),
    .q     (v_sync_s)
  );

  // Edge register: one cycle of history on the synchronized valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_dly_r <= 1'b0;
    end else begin
      v_dly_r <= v_sync_s;
    end
  end

  // The count set is only sampled on this rise, by which point it has been
  // stable for two clk cycles and is safe to capture without a synchronizer.
  assign rise_s = v_sync_s & ~v_dly_r;

  // Bitwise majority: strictly more than half of the evaluations voted 1.
  always_comb begin
    maj_s = '0;
    for (int i = 0; i < CNT_SET; i++) begin
      maj_s[i] = (vote_r[i] > HALF);
    end
  end

  // Collector FSM with its counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      o_busy       <= 1'b0;
      o_puf_en     <= 1'b0;
      o_resp_valid <= 1'b0;
      o_resp       <= '0;
      o_err        <= 1'b0;
      eval_cnt_r   <= '0;
      tmo_r        <= '0;
      for (int i = 0; i < CNT_SET; i++) begin
        vote_r[i] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (i_start) begin
            state_r    <= RUN;
            o_busy     <= 1'b1;
            o_puf_en   <= 1'b1;
            o_err      <= 1'b0;
            eval_cnt_r <= '0;
            tmo_r      <= '0;
            for (int i = 0; i < CNT_SET; i++) begin
              vote_r[i] <= '0;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        RUN: begin
          // A rise wins over a simultaneous timeout.
          if (rise_s) begin
            for (int i = 0; i < CNT_SET; i++) begin
              vote_r[i] <= vote_r[i] + VW'(i_puf_count_set[i]);
            end
            eval_cnt_r <= eval_cnt_r + VW'(1'b1);
            tmo_r      <= '0;
            o_puf_en   <= 1'b0;
            state_r    <= GAP;
          end else if (tmo_r == TMO_LAST) begin
            o_err    <= 1'b1;
            o_puf_en <= 1'b0;
            o_busy   <= 1'b0;
            tmo_r    <= '0;
            state_r  <= IDLE;
          end else begin
            tmo_r <= tmo_r + TW'(1'b1);
          end
        end

        GAP: begin
          // Hold off the next enable until puf_top has dropped its valid, so
          // the next rise really belongs to a fresh evaluation.
          if (!v_sync_s) begin
            tmo_r <= '0;
            if (eval_cnt_r == EVAL_ALL) begin
              o_resp       <= maj_s;
              o_resp_valid <= 1'b1;
              state_r      <= OUT;
            end else begin
              o_puf_en <= 1'b1;
              state_r  <= RUN;
            end
          end else if (tmo_r == TMO_LAST) begin
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            tmo_r   <= '0;
            state_r <= IDLE;
          end else begin
            tmo_r <= tmo_r + TW'(1'b1);
          end
        end

        OUT: begin
          // o_resp deliberately keeps its value after the handshake.
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            o_busy       <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= OUT;
          end
        end

        default: begin
          state_r      <= IDLE;
          o_busy       <= 1'b0;
          o_puf_en     <= 1'b0;
          o_resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_collector.sv
// -----------------------------------------------------------------------------
// tb_puf_resp_collector
// Self-checking bench for puf_resp_collector (N_EVAL=3, TIMEOUT=64). A
// behavioural PUF responder is driven from tasks; expected responses go into a
// scoreboard queue and a separate monitor compares them at each handshake.
// -----------------------------------------------------------------------------
module tb_puf_resp_collector;

  localparam int CNT_SET = 32;
  localparam int N_EVAL  = 3;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_start = 1'b0;
  logic               i_puf_valid = 1'b0;
  logic [CNT_SET-1:0] i_puf_count_set = '0;
  logic               i_resp_ready = 1'b0;
  logic               o_busy;
  logic               o_puf_en;
  logic               o_resp_valid;
  logic [CNT_SET-1:0] o_resp;
  logic               o_err;

  int errors = 0;
  int checks = 0;
  int en_pulses = 0;
  logic [CNT_SET-1:0] exp_q[$];

  always #5 clk = ~clk;

  puf_resp_collector #(
    .CNT_SET (CNT_SET),
    .N_EVAL  (N_EVAL),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .o_busy          (o_busy),
    .o_puf_en        (o_puf_en),
    .i_puf_valid     (i_puf_valid),
    .i_puf_count_set (i_puf_count_set),
    .o_resp_valid    (o_resp_valid),
    .i_resp_ready    (i_resp_ready),
    .o_resp          (o_resp),
    .o_err           (o_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per bit, count the ones over all evaluations and take the
  // strict majority.
  function automatic logic [CNT_SET-1:0] majority(input logic [CNT_SET-1:0] v [N_EVAL]);
    logic [CNT_SET-1:0] r;
    int n;
    r = '0;
    for (int b = 0; b < CNT_SET; b++) begin
      n = 0;
      for (int e = 0; e < N_EVAL; e++) n += int'(v[e][b]);
      r[b] = (2 * n > N_EVAL);
    end
    return r;
  endfunction

  // Scoreboard monitor: checks stability while valid is held and the value at
  // every handshake.
  initial begin
    logic               held_act;
    logic [CNT_SET-1:0] held_val;
    held_act = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (rst_n && o_resp_valid) begin
        if (held_act) check("resp_stable", o_resp, held_val);
        else begin
          held_act = 1'b1;
          held_val = o_resp;
        end
        if (i_resp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got %h expected none", o_resp);
          end else begin
            check("resp_value", o_resp, exp_q.pop_front());
            check("resp_err", 32'(o_err), 32'd0);
          end
          held_act = 1'b0;
        end
      end else begin
        held_act = 1'b0;
      end
    end
  end

  // Counts rising edges of o_puf_en.
  initial begin
    logic en_prev;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_puf_en && !en_prev) en_pulses++;
      en_prev = o_puf_en;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  // One PUF evaluation: wait for enable, answer with val, hold valid for hold
  // cycles after capture. Optionally checks GAP behaviour and re-enable latency.
  task automatic do_eval(input logic [CNT_SET-1:0] val, input int hold,
                         input bit gap_chk, input bit last, output bit ok);
    int k;
    ok = 1'b0;
    k = 0;
    while (!o_puf_en && k < 2 * TIMEOUT) begin tick(); k++; end
    if (!o_puf_en) begin fail_now("en_wait"); return; end
    repeat ($urandom_range(0, 5)) tick();
    i_puf_count_set = val;
    i_puf_valid = 1'b1;
    k = 0;
    while (o_puf_en && k < 20) begin tick(); k++; end
    check("capture_latency", 32'(k), 32'd3);
    for (int h = 0; h < hold; h++) begin
      tick();
      if (gap_chk) begin
        check("gap_en_low", 32'(o_puf_en), 32'd0);
        check("gap_busy", 32'(o_busy), 32'd1);
      end
    end
    i_puf_valid = 1'b0;
    i_puf_count_set = $urandom();
    if (gap_chk && !last) begin
      k = 0;
      while (!o_puf_en && k < 20) begin tick(); k++; end
      check("reenable_latency", 32'(k), 32'd3);
    end
    ok = 1'b1;
  endtask

  // Full response: start, N_EVAL evaluations, then the output handshake after
  // rd cycles of backpressure (optionally with start pulses during it).
  task automatic run_resp(input logic [CNT_SET-1:0] v0, input logic [CNT_SET-1:0] v1,
                          input logic [CNT_SET-1:0] v2, input int hold, input int rd,
                          input bit gap_chk, input bit start_bp);
    logic [CNT_SET-1:0] vals [N_EVAL];
    logic [CNT_SET-1:0] exp_v;
    bit ok;
    int k;
    vals = '{v0, v1, v2};
    exp_v = majority(vals);
    exp_q.push_back(exp_v);
    en_pulses = 0;
    i_resp_ready = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("busy_after_start", 32'(o_busy), 32'd1);
    check("err_after_start", 32'(o_err), 32'd0);
    for (int e = 0; e < N_EVAL; e++) begin
      do_eval(vals[e], hold, gap_chk, e == N_EVAL - 1, ok);
      if (!ok) return;
    end
    k = 0;
    while (!o_resp_valid && k < 30) begin tick(); k++; end
    if (!o_resp_valid) begin fail_now("resp_valid_wait"); return; end
    check("en_pulse_count", 32'(en_pulses), 32'(N_EVAL));
    for (int j = 0; j < rd; j++) begin
      i_start = start_bp && (j % 3 == 0);
      tick();
      check("bp_valid_held", 32'(o_resp_valid), 32'd1);
    end
    i_start = 1'b0;
    i_resp_ready = 1'b1;
    tick();
    i_resp_ready = 1'b0;
    check("idle_busy", 32'(o_busy), 32'd0);
    check("idle_valid", 32'(o_resp_valid), 32'd0);
    check("resp_kept", o_resp, exp_v);
    if (start_bp) begin
      tick();
      tick();
      check("bp_start_ignored", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    int k;
    bit ok;

    // Reset state.
    #2;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_en", 32'(o_puf_en), 32'd0);
    check("rst_valid", 32'(o_resp_valid), 32'd0);
    check("rst_resp", o_resp, 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Identical evaluations, then a genuine majority vote.
    run_resp(32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1, 0, 1'b0, 1'b0);
    run_resp(32'hA5A5_A5A5, 32'hA5A5_A5A4, 32'h5A5A_5A5A, 2, 0, 1'b0, 1'b0);

    // Backpressure with ignored start pulses.
    run_resp(32'h1234_5678, 32'h0F0F_F0F0, 32'hFFFF_0001, 0, 10, 1'b0, 1'b1);

    // Slow valid release: valid held 20 cycles after each capture.
    run_resp(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_FFFF, 20, 2, 1'b1, 1'b0);

    // Timeout: PUF never answers.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("tmo_en_on", 32'(o_puf_en), 32'd1);
    k = 0;
    while (!o_err && k < 200) begin tick(); k++; end
    check("tmo_cycles", 32'(k), 32'(TIMEOUT));
    check("tmo_en_off", 32'(o_puf_en), 32'd0);
    check("tmo_busy", 32'(o_busy), 32'd0);
    check("tmo_valid", 32'(o_resp_valid), 32'd0);
    repeat (3) tick();
    check("tmo_err_sticky", 32'(o_err), 32'd1);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("tmo_err_cleared", 32'(o_err), 32'd0);
    k = 0;
    while (o_busy && k < 200) begin tick(); k++; end
    check("tmo_err_again", 32'(o_err), 32'd1);

    // Reset during the second RUN of an evaluation sequence.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    do_eval(32'h1111_2222, 0, 1'b0, 1'b0, ok);
    k = 0;
    while (!o_puf_en && k < 20) begin tick(); k++; end
    tick();
    #2;
    rst_n = 1'b0;
    i_puf_valid = 1'b0;
    #1;
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_en", 32'(o_puf_en), 32'd0);
    check("arst_valid", 32'(o_resp_valid), 32'd0);
    check("arst_resp", o_resp, 32'd0);
    check("arst_err", 32'(o_err), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_resp(32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 1, 1, 1'b0, 1'b0);

    // Randomized responses, holds and backpressure.
    for (int r = 0; r < 10; r++) begin
      run_resp($urandom(), $urandom(), $urandom(),
               $urandom_range(0, 6), $urandom_range(0, 4), 1'b0, 1'b0);
    end

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
